// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx receiver: FSM state encoding,
// data width, minimum baud divisor and the divisor calculation.
package uart_rx_pkg;

  localparam int DATA_W  = 8;
  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchroniser for the serial line, resetting to the idle level (1).
// With UART_RX_GLITCH_FILTER_EN defined, a 3-sample majority vote follows it.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rxs_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  // Window = current synchroniser output plus two history taps, so the
  // filtered line lags the plain one by exactly one cycle.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign rxs_o = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rxs_o = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 / 8E1 UART receiver: FSM, baud counter, shift register, output registers.
// Optional majority filter on the line via UART_RX_GLITCH_FILTER_EN (see uart_rx_sync).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 781250,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              rx_en,
  output logic [DATA_W-1:0] data_o,
  output logic              word_done,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if (DIV < MIN_DIV) begin : g_div_check
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic rxs;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx),
    .rxs_o (rxs)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q;
  logic              word_done_q, perr_q, ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_en && !rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
            par_d   = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_W-1:1]};
          par_d   = par_q ^ rxs;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = par_q ^ rxs;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          // IDLE is re-entered here so a back-to-back start edge is not missed
          cnt_d   = '0;
          stop_d  = rxs;
          done_d  = 1'b1;
          state_d = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      word_done_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      word_done_q <= done_q;
      if (done_q) begin
        data_q <= shift_q;
        perr_q <= (PARITY_EN != 0) && par_q;
        ferr_q <= !stop_q;
      end
    end
  end

  assign data_o       = data_q;
  assign word_done    = word_done_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance (a) and an 8E1 instance (b),
// with expected frames queued at stimulus time and matched against observed strobes.
module tb_uart_rx;

  localparam int DIV = 32;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  // pin-to-rxs (2) + first IDLE edge (1) + stop sample offset + output register (1)
  localparam int LAT = 3 + DIV / 2 + 9 * DIV + 1 + FILT;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] data_a, data_b;
  logic       wd_a, wd_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  frame_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  uart_rx dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_en(rx_en), .data_o(data_a), .word_done(wd_a),
    .parity_err_o(perr_a), .frame_err_o(ferr_a), .busy_o(busy_a)
  );

  uart_rx #(.PARITY_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_en(rx_en), .data_o(data_b), .word_done(wd_b),
    .parity_err_o(perr_b), .frame_err_o(ferr_b), .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wd_a) obs_a.push_back('{cyc: cyc, data: data_a, perr: perr_a, ferr: ferr_a});
    if (wd_b) obs_b.push_back('{cyc: cyc, data: data_b, perr: perr_b, ferr: ferr_b});
  end

  task automatic drive_line(input bit sel_b, input logic v);
    if (sel_b) rx_b = v;
    else rx_a = v;
  endtask

  // Call at a falling edge; returns at the falling edge ending the stop bit.
  task automatic send_frame(input bit sel_b, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    drive_line(sel_b, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel_b, d[i]);
      repeat (DIV) @(negedge clk);
    end
    if (with_par) begin
      drive_line(sel_b, par);
      repeat (DIV) @(negedge clk);
    end
    drive_line(sel_b, stop);
    repeat (DIV) @(negedge clk);
  endtask

  task automatic wait_obs(input bit sel_b, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel_b ? obs_b.size() : obs_a.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (data_a !== 8'h00 || data_b !== 8'h00) begin $display("FAIL reset_data: a=%h b=%h required 00", data_a, data_b); errors++; end
    checks++; if (wd_a !== 1'b0 || wd_b !== 1'b0) begin $display("FAIL reset_word_done: a=%b b=%b required 0", wd_a, wd_b); errors++; end
    checks++; if ({perr_a, ferr_a, perr_b, ferr_b} !== 4'b0) begin $display("FAIL reset_flags: %b required 0000", {perr_a, ferr_a, perr_b, ferr_b}); errors++; end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin $display("FAIL reset_busy: a=%b b=%b required 0", busy_a, busy_b); errors++; end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    frame_t e, g;
    bit     ok;
    exp_a.push_back('{cyc: cyc + LAT, data: 8'h55, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_obs(1'b0, 1, 4 * DIV, ok);
    checks++;
    if (!ok) begin $display("FAIL basic_timeout: got %0d frames required 1", obs_a.size()); errors++; exp_a.delete(); return; end
    e = exp_a.pop_front(); g = obs_a.pop_front();
    checks++; if (g.data !== e.data) begin $display("FAIL basic_data: got %h required %h", g.data, e.data); errors++; end
    checks++; if (g.cyc !== e.cyc) begin $display("FAIL basic_latency: got cycle %0d required %0d", g.cyc, e.cyc); errors++; end
    checks++; if ({g.perr, g.ferr} !== 2'b00) begin $display("FAIL basic_flags: got %b required 00", {g.perr, g.ferr}); errors++; end
    repeat (2 * DIV) @(negedge clk);
    checks++; if (obs_a.size() != 0) begin $display("FAIL basic_single_pulse: got %0d extra required 0", obs_a.size()); errors++; obs_a.delete(); end
  endtask

  task automatic test_parity();
    frame_t e, g;
    bit     ok;
    for (int k = 0; k < 2; k++) begin
      logic pbit;
      pbit = (k == 0) ? 1'b1 : 1'b0;
      exp_b.push_back('{cyc: cyc + LAT + DIV, data: 8'hA5, perr: pbit, ferr: 1'b0});
      send_frame(1'b1, 8'hA5, 1'b1, pbit, 1'b1);
      wait_obs(1'b1, 1, 4 * DIV, ok);
      checks++;
      if (!ok) begin $display("FAIL parity_timeout: pass %0d got no frame", k); errors++; exp_b.delete(); return; end
      e = exp_b.pop_front(); g = obs_b.pop_front();
      checks++; if (g.data !== e.data) begin $display("FAIL parity_data: got %h required %h", g.data, e.data); errors++; end
      checks++; if (g.perr !== e.perr) begin $display("FAIL parity_flag: pass %0d got %b required %b", k, g.perr, e.perr); errors++; end
      checks++; if (g.cyc !== e.cyc || g.ferr !== 1'b0) begin $display("FAIL parity_timing: cycle %0d ferr %b required %0d 0", g.cyc, g.ferr, e.cyc); errors++; end
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_break();
    frame_t e, g;
    bit     ok;
    exp_a.push_back('{cyc: cyc + LAT, data: 8'h00, perr: 1'b0, ferr: 1'b1});
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin $display("FAIL break_busy: got %b required 1", busy_a); errors++; end
    checks++; if (obs_a.size() != 1) begin $display("FAIL break_pulses: got %0d required 1", obs_a.size()); errors++; end
    if (obs_a.size() != 0) begin
      e = exp_a.pop_front(); g = obs_a.pop_front();
      checks++; if (g.ferr !== 1'b1) begin $display("FAIL break_frame_err: got %b required 1", g.ferr); errors++; end
      checks++; if (g.cyc !== e.cyc) begin $display("FAIL break_latency: got cycle %0d required %0d", g.cyc, e.cyc); errors++; end
    end
    exp_a.delete(); obs_a.delete();
    rx_a = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin $display("FAIL break_exit: busy got %b required 0", busy_a); errors++; end
    exp_a.push_back('{cyc: cyc + LAT, data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_obs(1'b0, 1, 4 * DIV, ok);
    checks++;
    if (!ok) begin $display("FAIL break_recover_timeout: no frame after break"); errors++; exp_a.delete(); return; end
    e = exp_a.pop_front(); g = obs_a.pop_front();
    checks++; if (g.data !== e.data || g.ferr !== e.ferr) begin $display("FAIL break_recover: got %h ferr %b required %h ferr %b", g.data, g.ferr, e.data, e.ferr); errors++; end
    checks++; if (obs_a.size() != 0) begin $display("FAIL break_extra: got %0d extra frames required 0", obs_a.size()); errors++; obs_a.delete(); end
  endtask

  task automatic test_glitch();
    bit seen;
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    checks++; if (busy_a !== 1'b1) begin $display("FAIL glitch_busy_set: got %b required 1", busy_a); errors++; end
    repeat (17) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin $display("FAIL glitch_busy_clear: got %b required 0", busy_a); errors++; end
    repeat (11 * DIV) @(negedge clk);
    checks++; if (obs_a.size() != 0) begin $display("FAIL glitch_no_frame: got %0d frames required 0", obs_a.size()); errors++; obs_a.delete(); end
`ifdef UART_RX_GLITCH_FILTER_EN
    seen = 1'b0;
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * DIV) begin
      if (busy_a) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin $display("FAIL filter_one_cycle: busy got 1 required 0"); errors++; end
`else
    seen = 1'b0;
`endif
  endtask

  task automatic test_rx_en();
    bit seen;
    seen = 1'b0;
    rx_en = 1'b0;
    fork
      send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
      repeat (10 * DIV - 1) begin
        if (busy_a) seen = 1'b1;
        @(negedge clk);
      end
    join
    rx_en = 1'b1;
    repeat (DIV) @(negedge clk);
    checks++; if (seen !== 1'b0) begin $display("FAIL rx_en_busy: got 1 required 0"); errors++; end
    checks++; if (obs_a.size() != 0) begin $display("FAIL rx_en_no_frame: got %0d frames required 0", obs_a.size()); errors++; obs_a.delete(); end
  endtask

  task automatic test_back_to_back();
    frame_t e1, e2, g1, g2;
    bit     ok;
    exp_a.push_back('{cyc: cyc + LAT, data: 8'h48, perr: 1'b0, ferr: 1'b0});
    exp_a.push_back('{cyc: cyc + 10 * DIV + LAT, data: 8'h69, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h48, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h69, 1'b0, 1'b0, 1'b1);
    wait_obs(1'b0, 2, 4 * DIV, ok);
    checks++;
    if (!ok) begin $display("FAIL b2b_timeout: got %0d frames required 2", obs_a.size()); errors++; exp_a.delete(); obs_a.delete(); return; end
    e1 = exp_a.pop_front(); g1 = obs_a.pop_front();
    e2 = exp_a.pop_front(); g2 = obs_a.pop_front();
    checks++; if (g1.data !== e1.data) begin $display("FAIL b2b_first: got %h required %h", g1.data, e1.data); errors++; end
    checks++; if (g2.data !== e2.data) begin $display("FAIL b2b_second: got %h required %h", g2.data, e2.data); errors++; end
    checks++; if (g2.cyc - g1.cyc !== 10 * DIV) begin $display("FAIL b2b_spacing: got %0d required %0d", g2.cyc - g1.cyc, 10 * DIV); errors++; end
    checks++; if (g1.cyc !== e1.cyc) begin $display("FAIL b2b_latency: got cycle %0d required %0d", g1.cyc, e1.cyc); errors++; end
  endtask

  task automatic test_reset_mid();
    frame_t e, g;
    bit     ok;
    rx_a = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (data_a !== 8'h00) begin $display("FAIL midrst_data: got %h required 00", data_a); errors++; end
    checks++; if ({wd_a, perr_a, ferr_a, busy_a} !== 4'b0) begin $display("FAIL midrst_status: got %b required 0000", {wd_a, perr_a, ferr_a, busy_a}); errors++; end
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checks++; if (obs_a.size() != 0) begin $display("FAIL midrst_spurious: got %0d frames required 0", obs_a.size()); errors++; obs_a.delete(); end
    exp_a.push_back('{cyc: cyc + LAT, data: 8'h7E, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    wait_obs(1'b0, 1, 4 * DIV, ok);
    checks++;
    if (!ok) begin $display("FAIL midrst_timeout: no frame after reset"); errors++; exp_a.delete(); return; end
    e = exp_a.pop_front(); g = obs_a.pop_front();
    checks++; if (g.data !== e.data || g.cyc !== e.cyc) begin $display("FAIL midrst_frame: got %h at %0d required %h at %0d", g.data, g.cyc, e.data, e.cyc); errors++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_rx_en();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
